// File: rtl/mode_tick_ctrl_if.sv
// Signal bundle between the turn-signal mode controller and the board/pattern side.
// No handshake: buttons are raw levels; tick and mode_reset are single-cycle strobes with no backpressure.
interface mode_tick_ctrl_if;
    logic       btn_left;
    logic       btn_right;
    logic       btn_hazard;
    logic [1:0] mode;
    logic       en_left;
    logic       en_right;
    logic       en_hazard;
    logic       tick;
    logic       mode_reset;

    modport master (
        output btn_left, btn_right, btn_hazard,
        input  mode, en_left, en_right, en_hazard, tick, mode_reset
    );

    modport slave (
        input  btn_left, btn_right, btn_hazard,
        output mode, en_left, en_right, en_hazard, tick, mode_reset
    );
endinterface

// File: rtl/mode_tick_ctrl.sv
// Turn-signal mode controller: debounced buttons drive an OFF/LEFT/RIGHT/HAZARD mode FSM,
// plus the shared step tick that restarts on every mode change.
module mode_tick_ctrl #(
    parameter int TICK_DIV   = 12_500_000,
    parameter int DEB_CYCLES = 1_250_000
) (
    input logic            clk,
    input logic            reset,
    mode_tick_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_HAZARD = 2'b11
    } mode_t;

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // Bit order everywhere: [0] left, [1] right, [2] hazard
    logic [2:0]    btn_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_d;
    logic [2:0]    press;
    logic [DW-1:0] deb_cnt [3];

    mode_t         mode_q;
    mode_t         mode_next;
    logic          mode_reset_q;
    logic          en_left_q;
    logic          en_right_q;
    logic          en_hazard_q;
    logic [TW-1:0] tick_cnt;

    assign btn_raw = {bus.btn_hazard, bus.btn_right, bus.btn_left};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // A level is accepted only after DEB_CYCLES consecutive cycles of disagreement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            stable_d <= stable;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign press = stable & ~stable_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q       <= MODE_OFF;
            mode_reset_q <= 1'b0;
            en_left_q    <= 1'b0;
            en_right_q   <= 1'b0;
            en_hazard_q  <= 1'b0;
        end else begin
            mode_q       <= mode_next;
            mode_reset_q <= (mode_next != mode_q);
            en_left_q    <= (mode_next == MODE_LEFT);
            en_right_q   <= (mode_next == MODE_RIGHT);
            en_hazard_q  <= (mode_next == MODE_HAZARD);
        end
    end

    // Hazard wins; a simultaneous left+right press cancels out
    always_comb begin
        mode_next = mode_q;
        if (press[2]) begin
            mode_next = (mode_q == MODE_HAZARD) ? MODE_OFF : MODE_HAZARD;
        end else if (press[0] && !press[1]) begin
            case (mode_q)
                MODE_LEFT:   mode_next = MODE_OFF;
                MODE_HAZARD: mode_next = MODE_HAZARD;
                default:     mode_next = MODE_LEFT;
            endcase
        end else if (press[1] && !press[0]) begin
            case (mode_q)
                MODE_RIGHT:  mode_next = MODE_OFF;
                MODE_HAZARD: mode_next = MODE_HAZARD;
                default:     mode_next = MODE_RIGHT;
            endcase
        end
    end

    // Clearing on mode_reset puts the first tick exactly TICK_DIV cycles after it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (mode_reset_q || tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign bus.tick       = (tick_cnt == TICK_LAST) && (mode_q != MODE_OFF) && !mode_reset_q;
    assign bus.mode       = mode_q;
    assign bus.mode_reset = mode_reset_q;
    assign bus.en_left    = en_left_q;
    assign bus.en_right   = en_right_q;
    assign bus.en_hazard  = en_hazard_q;
endmodule
